// File: rtl/sram_port_arbiter.sv
// Two-port fixed-priority arbiter in front of a single-port synchronous SRAM.
// Port 0 wins conflicts unless port 1 has been refused MAX_WAIT times in a row.
module sram_port_arbiter #(
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned W_ADDR   = 11,
  parameter int unsigned MAX_WAIT = 3,
  localparam int unsigned W_BYTES = W_DATA / 8
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_vld,
  output logic               req0_rdy,
  input  logic [W_ADDR-1:0]  req0_addr,
  input  logic [W_BYTES-1:0] req0_wen,
  input  logic [W_DATA-1:0]  req0_wdata,
  output logic               rsp0_vld,
  output logic [W_DATA-1:0]  rsp0_rdata,

  input  logic               req1_vld,
  output logic               req1_rdy,
  input  logic [W_ADDR-1:0]  req1_addr,
  input  logic [W_BYTES-1:0] req1_wen,
  input  logic [W_DATA-1:0]  req1_wdata,
  output logic               rsp1_vld,
  output logic [W_DATA-1:0]  rsp1_rdata,

  output logic [W_ADDR-1:0]  sram_addr,
  output logic [W_BYTES-1:0] sram_wen,
  output logic [W_DATA-1:0]  sram_wdata,
  input  logic [W_DATA-1:0]  sram_rdata
);

  logic       gnt0;
  logic       gnt1;
  logic [3:0] starve_cnt;
  logic       rd_pend0;
  logic       rd_pend1;

  // Grant is purely a function of the valids, reset and the starvation count.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_vld && req1_vld) begin
        if (starve_cnt == 4'(MAX_WAIT)) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = req0_vld;
        gnt1 = req1_vld;
      end
    end
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;

  // With no grant the address/data follow port 0; only the write enables are forced off.
  always_comb begin
    sram_addr  = req0_addr;
    sram_wdata = req0_wdata;
    sram_wen   = '0;
    if (gnt1) begin
      sram_addr  = req1_addr;
      sram_wdata = req1_wdata;
      sram_wen   = req1_wen;
    end else if (gnt0) begin
      sram_wen   = req0_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      rd_pend0   <= 1'b0;
      rd_pend1   <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 && (req0_wen == '0);
      rd_pend1 <= gnt1 && (req1_wen == '0);
      if (gnt1) begin
        starve_cnt <= 4'd0;
      end else if (req1_vld && (starve_cnt < 4'(MAX_WAIT))) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // A read accepted just before reset rises must not surface while reset is held.
  assign rsp0_vld   = rd_pend0 && !rst;
  assign rsp1_vld   = rd_pend1 && !rst;
  assign rsp0_rdata = sram_rdata;
  assign rsp1_rdata = sram_rdata;

endmodule
